// File: rtl/mup_intc.sv
// rtl/mup_intc.sv - fixed-priority interrupt controller with ack/eoi handshake; INTC_NESTING_EN enables nesting
module mup_intc #(
   parameter int NSRC = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NSRC-1:0] irq,
   input  logic            mask_we,
   input  logic [NSRC-1:0] mask_wd,
   output logic            intr,     // interrupt request to the processor int input
   output logic [2:0]      vec,
   input  logic            ack,
   input  logic            eoi,
   output logic [NSRC-1:0] pend,
   output logic            busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] SERV = 2'd2;

   logic [1:0]      state;
   logic [NSRC-1:0] irq_d;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] isr;
   logic [NSRC-1:0] isr_next;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] elig;
   logic [NSRC-1:0] vec_bit;
   logic [NSRC-1:0] isr_low_bit;
   logic [2:0]      elig_idx;
   logic            take_ack;
   logic            take_eoi;
   logic            nest_ok;

   // Lowest set index wins; returns 0 for an all-zero input.
   function automatic logic [2:0] low_idx(input logic [NSRC-1:0] v);
      logic [2:0] r;
      r = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

   assign rise        = irq & ~irq_d;
   assign elig        = pend & ~mask;
   assign elig_idx    = low_idx(elig);
   assign vec_bit     = NSRC'(1) << vec;
   assign isr_low_bit = isr & (~isr + NSRC'(1));
   assign busy        = |isr;

   // Handshake qualification and the in-service update shared by the FSM.
   always_comb begin
      take_ack = (state == REQ) && ack;
      take_eoi = (state == SERV) && eoi;
      isr_next = isr;
      if (take_ack)      isr_next = isr | vec_bit;
      else if (take_eoi) isr_next = isr & ~isr_low_bit;
`ifdef INTC_NESTING_EN
      // A new source preempts only if it outranks every request in service.
      nest_ok = (state == SERV) && !eoi && (|elig) && (elig_idx < low_idx(isr));
`else
      nest_ok = 1'b0;
`endif
   end

   // Input edge history and mask register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_d <= '0;
         mask  <= '1;
      end else begin
         irq_d <= irq;
         if (mask_we) mask <= mask_wd;
      end
   end

   // Pending bits: set by rising edges, cleared by an accepting ack; set wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend <= '0;
      else        pend <= (pend & ~(take_ack ? vec_bit : '0)) | rise;
   end

   // Request/service FSM; int and vec are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         intr  <= 1'b0;
         vec   <= '0;
         isr   <= '0;
      end else begin
         isr <= isr_next;
         case (state)
            IDLE: begin
               if (|elig) begin
                  state <= REQ;
                  intr  <= 1'b1;
                  vec   <= elig_idx;
               end
            end
            REQ: begin
               if (ack) begin
                  state <= SERV;
                  intr  <= 1'b0;
               end
            end
            SERV: begin
               if (eoi) begin
                  state <= (|isr_next) ? SERV : IDLE;
               end else if (nest_ok) begin
                  state <= REQ;
                  intr  <= 1'b1;
                  vec   <= elig_idx;
               end
            end
            default: begin
               state <= IDLE;
               intr  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mup_intc.md
MUP_INTC -- requirements
Module: mup_intc

Interface
REQ-001 The block SHALL have parameter NSRC, default 8, meaning the number of interrupt sources (legal values 2..8); the vector width SHALL be fixed at 3 bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port irq, input, NSRC, level requests from peripherals, synchronous to clk.
REQ-005 The block SHALL have port mask_we, input, 1, mask write strobe.
REQ-006 The block SHALL have port mask_wd, input, NSRC, mask write data; 1 = source masked.
REQ-007 The block SHALL have port int, output, 1, interrupt request to the microprocessor int input.
REQ-008 The block SHALL have port vec, output, 3, the requested source index; valid while int=1.
REQ-009 The block SHALL have port ack, input, 1, one-cycle processor acknowledge pulse.
REQ-010 The block SHALL have port eoi, input, 1, one-cycle end-of-interrupt pulse.
REQ-011 The block SHALL have port pend, output, NSRC, the pending register.
REQ-012 The block SHALL have port busy, output, 1, high when any in-service bit is set.

Function
REQ-013 irq SHALL be registered into irq_d; a rising edge on source i (irq[i]=1, irq_d[i]=0) SHALL set pend[i] on the next clk edge.
REQ-014 pend[i] SHALL be cleared only by an ack that accepts source i; if an edge on i coincides with that clear, set SHALL win.
REQ-015 Eligible SHALL be defined as pend & ~mask; priority SHALL be fixed, with the lowest index highest.
REQ-016 The FSM SHALL have states IDLE, REQ and SERV.
REQ-017 IDLE: if eligible≠0, the FSM SHALL go to REQ and latch vec = the highest-priority eligible index.
REQ-018 REQ: int SHALL be 1 and vec SHALL be held constant; masking or a new higher-priority edge SHALL NOT retract or change the request.
REQ-019 REQ + ack: the block SHALL clear pend[vec], set isr[vec], drop int the next cycle and go to SERV.
REQ-020 SERV + eoi: the block SHALL clear the highest-priority set isr bit, then go to SERV if isr≠0, otherwise to IDLE.
REQ-021 ack outside REQ and eoi outside SERV SHALL be ignored; ack and eoi in the same REQ cycle SHALL process ack only.
REQ-022 Latency: an irq edge sampled at edge n SHALL produce pend at n+1 and int=1 after edge n+2.
REQ-023 mask_we SHALL update mask on the next edge; it SHALL NOT alter pend.
REQ-024 busy SHALL equal |isr, and int SHALL be a registered output.

Reset
REQ-025 When rst_n=0 asynchronously, the block SHALL set int=0, vec=0, pend=0, isr=0, irq_d=0, mask=all ones (all masked), busy=0 and FSM=IDLE.
REQ-026 Reset asserted mid-request SHALL drop int immediately, and no stale vec SHALL be presented after release.

Configuration
REQ-027 With INTC_NESTING_EN defined, in SERV an eligible source of strictly higher priority than every set isr bit SHALL move the FSM to REQ, allowing nesting of up to NSRC levels.
REQ-028 Without INTC_NESTING_EN, SERV SHALL ignore new requests until eoi, and isr SHALL hold at most one set bit.

Verification
REQ-029 Scenario: mask=0, irq[3] 0->1 -> pend[3]=1 one cycle later, int=1 with vec=3 the following cycle; ack -> int=0, busy=1, pend[3]=0; eoi -> busy=0, FSM=IDLE.
REQ-030 Scenario: edges on irq[5] and irq[2] in the same cycle -> vec=2 first; after ack and eoi, vec=5 is requested.
REQ-031 Scenario: mask=8'h10, edge on irq[4] -> pend[4]=1 and int stays 0; write mask=0 -> int=1 with vec=4 within 2 cycles.
REQ-032 Scenario: with INTC_NESTING_EN, in service of source 6, an edge on irq[1] -> int=1 with vec=1; ack -> isr=8'h42; first eoi -> isr=8'h40, FSM=SERV; without the macro, int stays 0 until eoi of source 6.
REQ-033 Scenario: rst_n pulsed low while int=1 with vec=3 -> int=0 at once; after release, int stays 0 until a new unmasked edge occurs.
REQ-034 Scenario: ack pulsed in IDLE and eoi pulsed in REQ -> no state change, and pend and isr are unchanged.
